// File: rtl/regfile_dump_reader.sv
// Walks a register-file index range on a spare read port and streams each value out over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append a trailing XOR-checksum beat to every dump.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [2:0]        dbg_state
);

    // Output handshake: a beat transfers on a clock edge where out_valid && out_ready;
    // out_valid/out_index/out_data/out_last never change while out_valid && !out_ready.
`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SEND  = 3'd2,
        S_DONE  = 3'd3,
        S_CSUM  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SEND  = 3'd2,
        S_DONE  = 3'd3
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
    logic [ADDR_W-1:0] end_idx_q, end_idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic              at_end;
    logic              handshake;
    logic [ADDR_W-1:0] next_idx;

    assign at_end    = (cur_idx_q == end_idx_q);
    assign handshake = out_valid_q && out_ready;
    // Explicit wrap so non-power-of-two register counts stay modulo NUM_REGS.
    assign next_idx  = (cur_idx_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_idx_q + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_idx_q   <= '0;
            end_idx_q   <= '0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            end_idx_q   <= end_idx_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        end_idx_d   = end_idx_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_idx_d = first_reg;
                    end_idx_d = last_reg;
                    rd_addr_d = first_reg;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d    = '0;
`endif
                    state_d   = S_SETUP;
                end
            end
            // rd_addr has been stable for a full cycle here, so rd_data is safe to capture.
            S_SETUP: begin
                out_data_d  = rd_data;
                out_index_d = cur_idx_q;
                out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                csum_d      = csum_q ^ rd_data;
`else
                out_last_d  = at_end;
`endif
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (at_end) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        cur_idx_d = next_idx;
                        rd_addr_d = next_idx;
                        state_d   = S_SETUP;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            // First cycle loads the checksum beat, then it is held until accepted.
            S_CSUM: begin
                if (!out_valid_q) begin
                    out_data_d  = csum_q;
                    out_index_d = end_idx_q;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr   = rd_addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign dbg_state = state_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/observability reader that sits on a spare read port of the multi-cycle CPU register file.
- On a start pulse, walks a register index range and reads each register.
- Streams each value out over a valid/ready handshake to the debug/trace path, tagged with its index.
- Never writes the register file. It is the read-side consumer of the write-back path that fills the register file.

Parameters:
- NUM_REGS, 32, number of architectural registers; index arithmetic is modulo NUM_REGS.
- ADDR_W, 5, register index width; equals log2(NUM_REGS).
- DATA_W, 32, register data width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_reg  in  ADDR_W  first index to dump; sampled with start.
- last_reg  in  ADDR_W  last index to dump; sampled with start.
- rd_addr  out  ADDR_W  read address to the register file read port.
- rd_data  in  DATA_W  register file read data; combinational from rd_addr.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse when the dump completes.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_index  out  ADDR_W  register index of the current beat.
- out_data  out  DATA_W  register value of the current beat.
- out_last  out  1  marks the final beat of the dump.

Behaviour:
- Reset values: all outputs 0, rd_addr=0, FSM=IDLE. Reset is asynchronous and may arrive mid-dump.
- Reset mid-dump: abort immediately with no done pulse. A pending beat is dropped (out_valid=0).
- FSM states: IDLE, SETUP, SEND, DONE (plus CSUM when the optional feature is enabled).
- IDLE:
  - On start=1: latch first_reg into cur_idx and last_reg into end_idx, drive rd_addr=first_reg, go to SETUP.
  - start is ignored in every other state.
- SETUP:
  - One settle cycle so rd_data reflects rd_addr; the register file's negedge write must not race the sample.
  - At the end of the cycle: out_data<=rd_data, out_index<=cur_idx, out_last<=(cur_idx==end_idx) (and optional feature disabled), out_valid<=1. Go to SEND.
- SEND:
  - Hold out_valid, out_data, out_index and out_last stable until out_valid&&out_ready.
  - On handshake with cur_idx==end_idx: clear out_valid, go to DONE (or CSUM if enabled).
  - On handshake otherwise: clear out_valid, cur_idx<=(cur_idx+1) mod NUM_REGS, rd_addr<=that value, go to SETUP.
- DONE: done=1 for exactly one cycle, busy drops, return to IDLE.
- Latency:
  - start at cycle 0 gives out_valid=1 at cycle 2.
  - With out_ready held high, throughput is one beat per 2 cycles.
- Wrap-around: if first_reg>last_reg, traverse first_reg..NUM_REGS-1 then 0..last_reg.
- Single register: first_reg==last_reg gives exactly one beat with out_last=1.
- Register 0 is dumped as read; the register file guarantees 0.
- A register written during the dump reflects whatever the read port shows in its SETUP cycle. No coherency beyond that is provided.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every dumped out_data is kept.
  - After the last register's handshake, the FSM enters CSUM and emits one extra beat: out_data=XOR, out_index=end_idx, out_last=1.
  - The data beats all have out_last=0.
  - DONE follows the CSUM handshake.
- Undefined: no CSUM state, no checksum logic, and the last register beat carries out_last=1.

Test Plan:
- Reset, regs r1..r3=0x11,0x22,0x33; start with first=1, last=3, out_ready=1 -> beats (1,0x11),(2,0x22),(3,0x33,last); out_valid first high at cycle 2; done pulse one cycle after the third handshake; busy low after that.
- first=30, last=1, r30=0xA, r31=0xB, r1=0xC -> indices 30,31,0,1 with data 0xA,0xB,0,0xC; out_last only on index 1.
- first=last=5, r5=0xDEADBEEF -> a single beat (5,0xDEADBEEF,last=1); done pulse.
- Backpressure: out_ready low for 4 cycles on beat 2 -> out_data/out_index stable and out_valid held; no index skipped; start pulses during busy are ignored.
- reset_n low while in SEND on index 2 -> all outputs 0 asynchronously, no done pulse; a new start afterwards restarts from first_reg.
- REGDUMP_CHECKSUM_EN, first=1, last=3, data 0x11,0x22,0x33 -> fourth beat out_data=0x00000000 (0x11^0x22^0x33), out_last=1 only on that beat.
